// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_if
// Purpose  : Request/response and byte-RAM bus between IF/LSB and mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rdy;
    logic              clr;
    logic              IF_S;
    logic [ADDR_W-1:0] IF_pc;
    logic              LSB_S;
    logic              LSB_op;
    logic [ADDR_W-1:0] LSB_addr;
    logic [2:0]        LSB_len;
    logic [DATA_W-1:0] LSB_value;
    logic              Mem_success;
    logic              Mem_type;
    logic [DATA_W-1:0] Mem_value;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport slave (
        input  rdy, clr, IF_S, IF_pc, LSB_S, LSB_op, LSB_addr, LSB_len, LSB_value,
               mem_din, io_buffer_full,
        output Mem_success, Mem_type, Mem_value, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, clr, IF_S, IF_pc, LSB_S, LSB_op, LSB_addr, LSB_len, LSB_value,
               mem_din, io_buffer_full,
        input  Mem_success, Mem_type, Mem_value, mem_dout, mem_a, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Arbitrates IF/LSB requests and serialises 1/2/4-byte accesses
//            onto a byte-wide RAM. Optional macro MEM_IO_STALL_EN holds stores
//            to the IO window while the UART buffer is full.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    mem_ctrl_if.slave   bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    logic [1:0]        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [2:0]        r_len, w_len_nxt;
    logic [2:0]        r_cyc, w_cyc_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_held, w_held_nxt;
    logic              r_success, w_success_nxt;
    logic              r_type, w_type_nxt;
    logic [DATA_W-1:0] r_value, w_value_nxt;
    logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
    logic [7:0]        r_dout, w_dout_nxt;
    logic              r_wr, w_wr_nxt;

    logic              w_idle_free;
    logic              w_accept_lsb;
    logic              w_accept_if;
    logic [2:0]        w_lsb_len;
    logic [1:0]        w_lane;
    logic [DATA_W-1:0] w_rd_capture;
    logic [DATA_W-1:0] w_rd_word;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_io_block;

    // The success cycle itself never accepts, so a still-raised request is not served twice.
    assign w_idle_free  = (r_state == c_IDLE) && !r_success;
    assign w_accept_lsb = w_idle_free && bus.LSB_S && (!bus.clr || bus.LSB_op);
    assign w_accept_if  = w_idle_free && !bus.LSB_S && bus.IF_S && !bus.clr;

    always_comb begin
        case (bus.LSB_len)
            3'd1:    w_lsb_len = 3'd1;
            3'd2:    w_lsb_len = 3'd2;
            default: w_lsb_len = 3'd4;
        endcase
    end

    // mem_din at a READ edge carries byte (r_cyc-1); r_held means it was already taken during a stall.
    assign w_lane       = r_cyc[1:0] - 2'd1;
    assign w_rd_capture = r_data | (DATA_W'(bus.mem_din) << {w_lane, 3'b000});
    assign w_rd_word    = r_held ? r_data : w_rd_capture;
    assign w_wr_addr    = (r_state == c_IDLE) ? bus.LSB_addr : r_addr + ADDR_W'(r_cyc);

`ifdef MEM_IO_STALL_EN
    assign w_io_block = (w_wr_addr[17:16] == 2'b11) && bus.io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = bus.io_buffer_full;
    assign w_io_block  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cyc     <= '0;
            r_data    <= '0;
            r_held    <= 1'b0;
            r_success <= 1'b0;
            r_type    <= 1'b0;
            r_value   <= '0;
            r_mem_a   <= '0;
            r_dout    <= '0;
            r_wr      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_len     <= w_len_nxt;
            r_cyc     <= w_cyc_nxt;
            r_data    <= w_data_nxt;
            r_held    <= w_held_nxt;
            r_success <= w_success_nxt;
            r_type    <= w_type_nxt;
            r_value   <= w_value_nxt;
            r_mem_a   <= w_mem_a_nxt;
            r_dout    <= w_dout_nxt;
            r_wr      <= w_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.rdy) begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept_lsb)     w_state_nxt = bus.LSB_op ? c_WRITE : c_READ;
                    else if (w_accept_if) w_state_nxt = c_READ;
                end
                c_READ:  if (bus.clr || r_cyc == r_len) w_state_nxt = c_IDLE;
                c_WRITE: if (r_cyc == r_len) w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_addr_nxt    = r_addr;
        w_len_nxt     = r_len;
        w_cyc_nxt     = r_cyc;
        w_data_nxt    = r_data;
        w_held_nxt    = r_held;
        w_success_nxt = r_success;
        w_type_nxt    = r_type;
        w_value_nxt   = r_value;
        w_mem_a_nxt   = r_mem_a;
        w_dout_nxt    = r_dout;
        w_wr_nxt      = r_wr;
        if (!bus.rdy) begin
            // The RAM keeps reading the frozen address, so grab the in-flight byte before it is lost.
            if (r_state == c_READ && r_cyc != 3'd0 && !r_held) begin
                w_data_nxt = w_rd_capture;
                w_held_nxt = 1'b1;
            end
        end else begin
            w_success_nxt = 1'b0;
            w_wr_nxt      = 1'b0;
            w_held_nxt    = 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept_lsb) begin
                        w_addr_nxt  = bus.LSB_addr;
                        w_len_nxt   = w_lsb_len;
                        w_type_nxt  = 1'b1;
                        w_mem_a_nxt = bus.LSB_addr;
                        w_cyc_nxt   = 3'd0;
                        if (bus.LSB_op) begin
                            w_data_nxt = bus.LSB_value;
                            if (!w_io_block) begin
                                w_dout_nxt = bus.LSB_value[7:0];
                                w_wr_nxt   = 1'b1;
                                w_cyc_nxt  = 3'd1;
                            end
                        end else begin
                            w_data_nxt = '0;
                        end
                    end else if (w_accept_if) begin
                        w_addr_nxt  = bus.IF_pc;
                        w_len_nxt   = 3'd4;
                        w_type_nxt  = 1'b0;
                        w_mem_a_nxt = bus.IF_pc;
                        w_data_nxt  = '0;
                        w_cyc_nxt   = 3'd0;
                    end
                end
                c_READ: begin
                    if (bus.clr) begin
                        w_cyc_nxt = 3'd0;
                    end else begin
                        if (r_cyc != 3'd0) w_data_nxt = w_rd_word;
                        if (r_cyc == r_len) begin
                            w_success_nxt = 1'b1;
                            w_value_nxt   = w_rd_word;
                            w_cyc_nxt     = 3'd0;
                        end else begin
                            w_cyc_nxt = r_cyc + 3'd1;
                            if (r_cyc + 3'd1 < r_len)
                                w_mem_a_nxt = r_addr + ADDR_W'(r_cyc + 3'd1);
                        end
                    end
                end
                c_WRITE: begin
                    if (r_cyc == r_len) begin
                        w_success_nxt = 1'b1;
                        w_cyc_nxt     = 3'd0;
                    end else begin
                        w_mem_a_nxt = w_wr_addr;
                        if (!w_io_block) begin
                            w_dout_nxt = r_data[{r_cyc[1:0], 3'b000} +: 8];
                            w_wr_nxt   = 1'b1;
                            w_cyc_nxt  = r_cyc + 3'd1;
                        end
                    end
                end
                default: w_cyc_nxt = 3'd0;
            endcase
        end
    end

    assign bus.Mem_success = r_success & bus.rdy;
    assign bus.Mem_type    = r_type;
    assign bus.Mem_value   = r_value;
    assign bus.mem_a       = r_mem_a;
    assign bus.mem_dout    = r_dout;
    assign bus.mem_wr      = r_wr & bus.rdy;
endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed bench for mem_ctrl with a byte-RAM model and a response
//            scoreboard (type, value and completion cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   succ_cnt = 0;
    int   t0 = 0;
    int   s0 = 0;

    typedef struct { logic typ; logic chk_val; logic [31:0] val; int at; } exp_t;
    typedef struct { int at; logic [31:0] a; logic [7:0] d; } wr_t;
    exp_t sb[$];
    wr_t  wlog[$];
    logic [7:0] ram [0:4095];

    mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM with one-cycle registered read; preloaded while reset is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
            ram[12'h104] <= 8'h55; ram[12'h105] <= 8'h66;
            ram[12'h106] <= 8'h77; ram[12'h107] <= 8'h88;
            ram[12'h202] <= 8'h77; ram[12'hFFF] <= 8'h5A;
            ram[12'h000] <= 8'hA5;
        end else if (bus.mem_wr === 1'b1) begin
            ram[bus.mem_a[11:0]] <= bus.mem_dout;
        end
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.mem_wr === 1'b1) wlog.push_back('{cyc, bus.mem_a, bus.mem_dout});
        if (!rst && bus.Mem_success === 1'b1) begin
            exp_t e;
            succ_cnt++;
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_type", 64'(bus.Mem_type), 64'(e.typ));
                check("resp_cycle", 64'(cyc), 64'(e.at));
                if (e.chk_val) check("resp_value", 64'(bus.Mem_value), 64'(e.val));
            end
        end
    end

    task automatic push_exp(input logic typ, input logic chk, input logic [31:0] val, input int at);
        sb.push_back('{typ, chk, val, at});
    endtask

    task automatic begin_step();
        @(negedge clk);
        t0 = cyc;
        wlog.delete();
    endtask

    task automatic lsb_go(input logic op, input logic [31:0] addr, input logic [2:0] len,
                          input logic [31:0] val);
        bus.LSB_S = 1'b1; bus.LSB_op = op; bus.LSB_addr = addr;
        bus.LSB_len = len; bus.LSB_value = val;
    endtask

    task automatic wait_success(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.Mem_success !== 1'b1 && n < 60);
        check({tag, "_done"}, 64'(bus.Mem_success), 64'd1);
    endtask

    task automatic check_wr(input string tag, input int idx, input int at, input logic [31:0] a,
                            input logic [7:0] d);
        if (wlog.size() > idx) begin
            check({tag, "_at"}, 64'(wlog[idx].at), 64'(at));
            check({tag, "_a"}, 64'(wlog[idx].a), 64'(a));
            check({tag, "_d"}, 64'(wlog[idx].d), 64'(d));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rdy = 1'b1; bus.clr = 1'b0; bus.IF_S = 1'b0; bus.IF_pc = '0;
        bus.LSB_S = 1'b0; bus.LSB_op = 1'b0; bus.LSB_addr = '0; bus.LSB_len = 3'd4;
        bus.LSB_value = '0; bus.io_buffer_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_success", 64'(bus.Mem_success), 64'd0);
        check("rst_type", 64'(bus.Mem_type), 64'd0);
        check("rst_value", 64'(bus.Mem_value), 64'd0);
        check("rst_mem_a", 64'(bus.mem_a), 64'd0);
        check("rst_dout", 64'(bus.mem_dout), 64'd0);
        check("rst_wr", 64'(bus.mem_wr), 64'd0);
        rst = 1'b0;

        // LW 0x100: five edges from accept
        begin_step();
        lsb_go(1'b0, 32'h100, 3'd4, 32'h0);
        push_exp(1'b1, 1'b1, 32'h44332211, t0 + 6);
        wait_success("lw"); bus.LSB_S = 1'b0;

        // SH 0xBEEF to 0x200, then LHU back
        begin_step();
        lsb_go(1'b1, 32'h200, 3'd2, 32'h1234BEEF);
        push_exp(1'b1, 1'b0, 32'h0, t0 + 3);
        wait_success("sh"); bus.LSB_S = 1'b0;
        check("sh_nwr", 64'(wlog.size()), 64'd2);
        check_wr("sh_w0", 0, t0 + 1, 32'h200, 8'hEF);
        check_wr("sh_w1", 1, t0 + 2, 32'h201, 8'hBE);

        begin_step();
        lsb_go(1'b0, 32'h200, 3'd2, 32'h0);
        push_exp(1'b1, 1'b1, 32'h0000BEEF, t0 + 4);
        wait_success("lhu"); bus.LSB_S = 1'b0;

        // Simultaneous LB and fetch: LSB first, fetch after the success cycle
        begin_step();
        lsb_go(1'b0, 32'h102, 3'd1, 32'h0);
        bus.IF_S = 1'b1; bus.IF_pc = 32'h100;
        push_exp(1'b1, 1'b1, 32'h00000033, t0 + 3);
        push_exp(1'b0, 1'b1, 32'h44332211, t0 + 10);
        wait_success("prio_lb"); bus.LSB_S = 1'b0;
        wait_success("prio_if"); bus.IF_S = 1'b0;

        // clr on the second byte of a fetch aborts it
        begin_step();
        s0 = succ_cnt;
        bus.IF_S = 1'b1; bus.IF_pc = 32'h104;
        repeat (2) @(negedge clk);
        bus.clr = 1'b1; bus.IF_S = 1'b0;
        @(negedge clk);
        bus.clr = 1'b0;
        repeat (8) @(negedge clk);
        check("clr_if_nosucc", 64'(succ_cnt), 64'(s0));
        check("clr_if_nowr", 64'(wlog.size()), 64'd0);

        begin_step();
        bus.IF_S = 1'b1; bus.IF_pc = 32'h104;
        push_exp(1'b0, 1'b1, 32'h88776655, t0 + 6);
        wait_success("refetch"); bus.IF_S = 1'b0;

        // clr during SW: store still completes
        begin_step();
        lsb_go(1'b1, 32'h300, 3'd4, 32'hCAFEF00D);
        push_exp(1'b1, 1'b0, 32'h0, t0 + 5);
        repeat (2) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        wait_success("clr_sw"); bus.LSB_S = 1'b0;
        check("clr_sw_nwr", 64'(wlog.size()), 64'd4);
        check("clr_sw_b0", 64'(ram[12'h300]), 64'h0D);
        check("clr_sw_b1", 64'(ram[12'h301]), 64'hF0);
        check("clr_sw_b2", 64'(ram[12'h302]), 64'hFE);
        check("clr_sw_b3", 64'(ram[12'h303]), 64'hCA);

        // In IDLE, clr blocks a load for that cycle but not a store
        begin_step();
        lsb_go(1'b0, 32'h101, 3'd1, 32'h0);
        bus.clr = 1'b1;
        push_exp(1'b1, 1'b1, 32'h00000022, t0 + 4);
        @(negedge clk);
        bus.clr = 1'b0;
        wait_success("clr_lb"); bus.LSB_S = 1'b0;

        begin_step();
        lsb_go(1'b1, 32'h310, 3'd1, 32'h0000005C);
        bus.clr = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0, t0 + 2);
        wait_success("clr_sb"); bus.LSB_S = 1'b0; bus.clr = 1'b0;
        check("clr_sb_nwr", 64'(wlog.size()), 64'd1);
        check_wr("clr_sb_w0", 0, t0 + 1, 32'h310, 8'h5C);

        // rdy low for 3 cycles mid-LW
        begin_step();
        lsb_go(1'b0, 32'h100, 3'd4, 32'h0);
        push_exp(1'b1, 1'b1, 32'h44332211, t0 + 9);
        repeat (2) @(negedge clk);
        bus.rdy = 1'b0;
        repeat (3) @(negedge clk);
        bus.rdy = 1'b1;
        wait_success("rdy_lw"); bus.LSB_S = 1'b0;

        // Unsupported length behaves as a word
        begin_step();
        lsb_go(1'b0, 32'h104, 3'd3, 32'h0);
        push_exp(1'b1, 1'b1, 32'h88776655, t0 + 6);
        wait_success("len3"); bus.LSB_S = 1'b0;

        // Halfword at the top of the address space wraps to 0
        begin_step();
        lsb_go(1'b0, 32'hFFFFFFFF, 3'd2, 32'h0);
        push_exp(1'b1, 1'b1, 32'h0000A55A, t0 + 4);
        wait_success("wrap"); bus.LSB_S = 1'b0;

        // SB to the IO window with the UART buffer full for 4 cycles
        begin_step();
        lsb_go(1'b1, 32'h00030000, 3'd1, 32'h00000041);
        bus.io_buffer_full = 1'b1;
`ifdef MEM_IO_STALL_EN
        push_exp(1'b1, 1'b0, 32'h0, t0 + 6);
        repeat (4) @(negedge clk);
        bus.io_buffer_full = 1'b0;
        wait_success("io"); bus.LSB_S = 1'b0;
        check("io_nwr", 64'(wlog.size()), 64'd1);
        check_wr("io_w0", 0, t0 + 5, 32'h00030000, 8'h41);
`else
        push_exp(1'b1, 1'b0, 32'h0, t0 + 2);
        wait_success("io"); bus.LSB_S = 1'b0; bus.io_buffer_full = 1'b0;
        check("io_nwr", 64'(wlog.size()), 64'd1);
        check_wr("io_w0", 0, t0 + 1, 32'h00030000, 8'h41);
`endif

        // Reset in the middle of a load abandons it
        begin_step();
        s0 = succ_cnt;
        lsb_go(1'b0, 32'h100, 3'd4, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1; bus.LSB_S = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_value", 64'(bus.Mem_value), 64'd0);
        check("mid_rst_mem_a", 64'(bus.mem_a), 64'd0);
        check("mid_rst_wr", 64'(bus.mem_wr), 64'd0);
        repeat (8) @(negedge clk);
        check("mid_rst_nosucc", 64'(succ_cnt), 64'(s0));

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
